// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the queued LSU: FSM states, AXI channel bundles, response codes
// and the byte-lane helpers used by both the issue and the read-return paths.
package ysyx_24080006_pkg;

    localparam int AXI_ADDR_W = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RSP   = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic                  awvalid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  wvalid;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
        logic                  wlast;
        logic                  bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
    } axi_w_s2m_t;

    typedef struct packed {
        logic                  arvalid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } axi_r_s2m_t;

    // Unshifted byte-enable pattern for an access size; size 3 is treated as a word.
    function automatic logic [3:0] size_strobe(input logic [1:0] size);
        logic [3:0] strb;
        case (size)
            SIZE_B:  strb = 4'b0001;
            SIZE_H:  strb = 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_H) && (off == 2'd3)) || (size[1] && (off != 2'd0));
    endfunction

    // zext=1 selects zero extension, zext=0 sign extension.
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                                input logic zext);
        logic [31:0] res;
        case (size)
            SIZE_B:  res = zext ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SIZE_H:  res = zext ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ysyx_24080006_lsu_reqq.sv
// Request FIFO for the LSU: DEPTH entries of WIDTH bits, registered full/empty,
// no bypass path (an entry is visible at the head the cycle after it is pushed).
module ysyx_24080006_lsu_reqq #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // DEPTH is a power of two, so the natural pointer overflow is the modulo wrap.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (DEPTH == 1) n = '0;
        else            n = p + PTR_W'(1);
        return n;
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ysyx_24080006_lsu_queued.sv
// Queued load/store unit: buffers requests, issues one AXI transaction at a time and
// returns responses in order. Define YSYX_24080006_LSU_MISALIGN_EN to split misaligned accesses.
module ysyx_24080006_lsu_queued
    import ysyx_24080006_pkg::*;
#(
    parameter int REQ_DEPTH = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misalign,
    output axi_w_m2s_t        lsu_w_m2s,
    input  axi_w_s2m_t        lsu_w_s2m,
    output axi_r_m2s_t        lsu_r_m2s,
    input  axi_r_s2m_t        lsu_r_s2m
);

`ifdef YSYX_24080006_LSU_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              sext;
        logic              write;
        logic [31:0]       wdata;
    } req_t;

    localparam int ENTRY_W = $bits(req_t);

    logic               q_full, q_empty, q_push, q_pop;
    logic [ENTRY_W-1:0] q_head_raw;
    req_t               q_head, q_in;

    lsu_state_e  state_q, state_d;
    req_t        cur_q, cur_d;
    logic        beat_q, beat_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] r1_q, r1_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_misalign_q, rsp_misalign_d;

    assign q_in      = '{addr: req_addr, size: req_size, sext: req_sext,
                         write: req_write, wdata: req_wdata};
    assign q_push    = req_valid && !q_full;
    assign req_ready = !q_full;
    assign q_head    = q_head_raw;

    ysyx_24080006_lsu_reqq #(
        .DEPTH(REQ_DEPTH),
        .WIDTH(ENTRY_W)
    ) u_reqq (
        .clock    (clock),
        .reset    (reset),
        .push     (q_push),
        .push_data(q_in),
        .pop      (q_pop),
        .pop_data (q_head_raw),
        .full     (q_full),
        .empty    (q_empty)
    );

    logic [1:0]            cur_off;
    logic                  cur_split;
    logic [4:0]            sh_lo, sh_hi;
    logic [7:0]            mask8;
    logic [AXI_ADDR_W-1:0] cur_addr, word_base;
    logic [AXI_ADDR_W-1:0] beat_addr;
    logic [2:0]            beat_size;
    logic [3:0]            beat_strb;
    logic [31:0]           beat_wdata;
    logic [31:0]           rd_raw;

    // sh_hi = 32 - 8*off (mod 32), i.e. the shift that brings the upper beat's low bytes into place.
    assign cur_off   = cur_q.addr[1:0];
    assign cur_split = MISALIGN_EN && is_misaligned(cur_q.size, cur_off);
    assign sh_lo     = {cur_off, 3'b000};
    assign sh_hi     = 5'd0 - sh_lo;
    assign mask8     = {4'b0000, size_strobe(cur_q.size)} << cur_off;
    assign cur_addr  = AXI_ADDR_W'(cur_q.addr);
    assign word_base = {cur_addr[AXI_ADDR_W-1:2], 2'b00};

    always_comb begin
        beat_addr  = cur_addr;
        beat_size  = {1'b0, (cur_q.size == 2'd3) ? SIZE_W : cur_q.size};
        beat_strb  = mask8[3:0];
        beat_wdata = cur_q.wdata << sh_lo;
        if (cur_split) begin
            beat_size = {1'b0, SIZE_W};
            beat_addr = word_base;
            if (beat_q) begin
                beat_addr  = word_base + AXI_ADDR_W'(4);
                beat_strb  = mask8[7:4];
                beat_wdata = cur_q.wdata >> sh_hi;
            end
        end
    end

    assign rd_raw = cur_split ? ((r1_q >> sh_lo) | (lsu_r_s2m.rdata << sh_hi))
                              : (lsu_r_s2m.rdata >> sh_lo);

    always_comb begin
        lsu_r_m2s         = '0;
        lsu_r_m2s.arvalid = (state_q == ST_ISSUE) && !cur_q.write;
        lsu_r_m2s.araddr  = beat_addr;
        lsu_r_m2s.arlen   = 8'd0;
        lsu_r_m2s.arsize  = beat_size;
        lsu_r_m2s.arburst = 2'b01;
        lsu_r_m2s.rready  = (state_q == ST_WAIT) && !cur_q.write;

        lsu_w_m2s         = '0;
        lsu_w_m2s.awvalid = (state_q == ST_ISSUE) && cur_q.write && !aw_done_q;
        lsu_w_m2s.awaddr  = beat_addr;
        lsu_w_m2s.awlen   = 8'd0;
        lsu_w_m2s.awsize  = beat_size;
        lsu_w_m2s.awburst = 2'b01;
        lsu_w_m2s.wvalid  = (state_q == ST_ISSUE) && cur_q.write && !w_done_q;
        lsu_w_m2s.wdata   = beat_wdata;
        lsu_w_m2s.wstrb   = lsu_w_m2s.wvalid ? beat_strb : 4'b0000;
        lsu_w_m2s.wlast   = 1'b1;
        lsu_w_m2s.bready  = (state_q == ST_WAIT) && cur_q.write;
    end

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        beat_d         = beat_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        r1_d           = r1_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        rsp_misalign_d = rsp_misalign_q;
        q_pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop     = 1'b1;
                    cur_d     = q_head;
                    beat_d    = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    // Without splitting support a misaligned access never reaches the bus.
                    if (!MISALIGN_EN && is_misaligned(q_head.size, q_head.addr[1:0])) begin
                        state_d        = ST_RSP;
                        rsp_rdata_d    = 32'h0;
                        rsp_err_d      = 1'b0;
                        rsp_misalign_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (cur_q.write) begin
                    aw_done_d = aw_done_q || (lsu_w_m2s.awvalid && lsu_w_s2m.awready);
                    w_done_d  = w_done_q || (lsu_w_m2s.wvalid && lsu_w_s2m.wready);
                    if (aw_done_d && w_done_d) begin
                        state_d   = ST_WAIT;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end else if (lsu_r_s2m.arready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cur_q.write && lsu_r_s2m.rvalid) begin
                    if (lsu_r_s2m.rresp != AXI_RESP_OKAY) begin
                        state_d        = ST_RSP;
                        rsp_rdata_d    = 32'h0;
                        rsp_err_d      = 1'b1;
                        rsp_misalign_d = 1'b0;
                    end else if (cur_split && !beat_q) begin
                        r1_d    = lsu_r_s2m.rdata;
                        beat_d  = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d        = ST_RSP;
                        rsp_rdata_d    = load_extend(rd_raw, cur_q.size, cur_q.sext);
                        rsp_err_d      = 1'b0;
                        rsp_misalign_d = 1'b0;
                    end
                end else if (cur_q.write && lsu_w_s2m.bvalid) begin
                    if (lsu_w_s2m.bresp != AXI_RESP_OKAY) begin
                        state_d        = ST_RSP;
                        rsp_rdata_d    = 32'h0;
                        rsp_err_d      = 1'b1;
                        rsp_misalign_d = 1'b0;
                    end else if (cur_split && !beat_q) begin
                        beat_d  = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d        = ST_RSP;
                        rsp_rdata_d    = 32'h0;
                        rsp_err_d      = 1'b0;
                        rsp_misalign_d = 1'b0;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cur_q          <= '0;
            beat_q         <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            r1_q           <= 32'h0;
            rsp_rdata_q    <= 32'h0;
            rsp_err_q      <= 1'b0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            beat_q         <= beat_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            r1_q           <= r1_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            rsp_misalign_q <= rsp_misalign_d;
        end
    end

    assign rsp_valid    = (state_q == ST_RSP);
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_misalign = rsp_misalign_q;

endmodule

// File: tb/tb_ysyx_24080006_lsu_queued.sv
// Directed bench for the queued LSU with a small reactive AXI slave; honours
// YSYX_24080006_LSU_MISALIGN_EN for the misaligned-load expectations.
module tb_ysyx_24080006_lsu_queued;
    import ysyx_24080006_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_sext = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_misalign;
    axi_w_m2s_t  w_m2s;
    axi_w_s2m_t  w_s2m;
    axi_r_m2s_t  r_m2s;
    axi_r_s2m_t  r_s2m;

    always #5 clock = ~clock;

    ysyx_24080006_lsu_queued #(.REQ_DEPTH(2), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_sext(req_sext), .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_misalign(rsp_misalign),
        .lsu_w_m2s(w_m2s), .lsu_w_s2m(w_s2m), .lsu_r_m2s(r_m2s), .lsu_r_s2m(r_s2m)
    );

    // Slave: ready always high, R/B one cycle after the address/data handshakes.
    logic        s_rvalid = 1'b0, s_bvalid = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    bit          ar_fire, r_fire, aw_seen, w_seen, b_fire, r_hold;
    int          b_delay = 0, b_cnt = 0, ar_cnt = 0, aw_cnt = 0;
    logic [31:0] rd_data_q[$];
    logic [1:0]  rd_resp_q[$];
    logic [31:0] araddr_log[$], awaddr_log[$], wdata_log[$];
    logic [3:0]  wstrb_log[$];

    always_comb begin
        r_s2m.arready = 1'b1;
        r_s2m.rvalid  = s_rvalid;
        r_s2m.rdata   = s_rdata;
        r_s2m.rresp   = s_rresp;
        w_s2m.awready = 1'b1;
        w_s2m.wready  = 1'b1;
        w_s2m.bvalid  = s_bvalid;
        w_s2m.bresp   = s_bresp;
    end

    always @(negedge clock) begin
        if (!reset) begin
            s_rvalid = 1'b0; s_bvalid = 1'b0;
            ar_fire = 0; r_fire = 0; aw_seen = 0; w_seen = 0; b_fire = 0;
        end else begin
            if (r_fire) begin s_rvalid = 1'b0; r_fire = 0; end
            if (ar_fire && !r_hold) begin
                s_rvalid = 1'b1;
                s_rdata  = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'h0;
                s_rresp  = (rd_resp_q.size() > 0) ? rd_resp_q.pop_front() : AXI_RESP_OKAY;
                ar_fire  = 0;
            end
            if (r_m2s.arvalid) begin ar_fire = 1; araddr_log.push_back(r_m2s.araddr); ar_cnt++; end
            if (s_rvalid && r_m2s.rready) r_fire = 1;

            if (b_fire) begin s_bvalid = 1'b0; b_fire = 0; end
            if (aw_seen && w_seen) begin
                if (b_cnt == 0) begin
                    s_bvalid = 1'b1; s_bresp = AXI_RESP_OKAY; aw_seen = 0; w_seen = 0;
                end else b_cnt--;
            end
            if (w_m2s.awvalid) begin aw_seen = 1; b_cnt = b_delay; awaddr_log.push_back(w_m2s.awaddr); aw_cnt++; end
            if (w_m2s.wvalid) begin w_seen = 1; wdata_log.push_back(w_m2s.wdata); wstrb_log.push_back(w_m2s.wstrb); end
            if (s_bvalid && w_m2s.bready) b_fire = 1;
        end
    end

    int          n_total = 0, n_bad = 0;
    logic [31:0] got_rdata;
    logic        got_err, got_mis;
    logic [31:0] resp_log[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                         input logic wr, input logic [31:0] wd);
        req_valid = 1'b1; req_addr = a; req_size = sz; req_sext = sx; req_write = wr; req_wdata = wd;
    endtask

    task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                        input logic wr, input logic [31:0] wd);
        int guard = 0;
        drive(a, sz, sx, wr, wd);
        while (!req_ready && guard < 50) begin tick(); guard++; end
        chk("send_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int guard = 0;
        while (!rsp_valid && guard < 60) begin tick(); guard++; end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        got_rdata = rsp_rdata; got_err = rsp_err; got_mis = rsp_misalign;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int base, got, guard;
        bit saw_b;

        // Reset state
        repeat (3) tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_arvalid",   32'(r_m2s.arvalid), 32'd0);
        chk("rst_awvalid",   32'(w_m2s.awvalid), 32'd0);
        chk("rst_wvalid",    32'(w_m2s.wvalid), 32'd0);
        chk("rst_araddr",    r_m2s.araddr, 32'h0);
        chk("rst_wstrb",     32'(w_m2s.wstrb), 32'h0);
        chk("rst_rdata",     rsp_rdata, 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // LW, latency and hold behaviour
        rd_data_q.push_back(32'hDEAD_BEEF); rd_resp_q.push_back(AXI_RESP_OKAY);
        base = ar_cnt;
        send(32'h8000_0000, SIZE_W, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        chk("lw_lat_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("lw_lat_4", 32'(rsp_valid), 32'd1);
        chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("lw_err", 32'(rsp_err), 32'd0);
        chk("lw_araddr", araddr_log[base], 32'h8000_0000);
        tick(); tick();
        chk("lw_hold_valid", 32'(rsp_valid), 32'd1);
        chk("lw_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
        wait_rsp("lw_ack");

        // LB sign-extend (sext=0) and LBU (sext=1)
        rd_data_q.push_back(32'h8000_0000); rd_resp_q.push_back(AXI_RESP_OKAY);
        send(32'h8000_0003, SIZE_B, 1'b0, 1'b0, 32'h0);
        wait_rsp("lb");
        chk("lb_rdata", got_rdata, 32'hFFFF_FF80);
        rd_data_q.push_back(32'h8000_0000); rd_resp_q.push_back(AXI_RESP_OKAY);
        send(32'h8000_0003, SIZE_B, 1'b1, 1'b0, 32'h0);
        wait_rsp("lbu");
        chk("lbu_rdata", got_rdata, 32'h0000_0080);

        // SH with a slow B channel
        b_delay = 3;
        base = aw_cnt;
        send(32'h8000_0002, SIZE_H, 1'b0, 1'b1, 32'h0000_1234);
        saw_b = 0; guard = 0;
        while (guard < 60) begin
            if (s_bvalid) saw_b = 1;
            if (rsp_valid) break;
            tick(); guard++;
        end
        chk("sh_b_before_rsp", 32'(saw_b), 32'd1);
        chk("sh_awaddr", awaddr_log[base], 32'h8000_0002);
        chk("sh_wstrb", 32'(wstrb_log[base]), 32'h0000_000C);
        chk("sh_wdata", wdata_log[base], 32'h1234_0000);
        wait_rsp("sh");
        chk("sh_err", 32'(got_err), 32'd0);
        b_delay = 0;

        // Misaligned LW
        base = ar_cnt;
`ifdef YSYX_24080006_LSU_MISALIGN_EN
        rd_data_q.push_back(32'h4433_2211); rd_resp_q.push_back(AXI_RESP_OKAY);
        rd_data_q.push_back(32'h8877_6655); rd_resp_q.push_back(AXI_RESP_OKAY);
        send(32'h8000_0001, SIZE_W, 1'b0, 1'b0, 32'h0);
        wait_rsp("mis");
        chk("mis_ar_cnt", 32'(ar_cnt - base), 32'd2);
        chk("mis_araddr0", araddr_log[base], 32'h8000_0000);
        chk("mis_araddr1", araddr_log[base+1], 32'h8000_0004);
        chk("mis_rdata", got_rdata, 32'h5544_3322);
        chk("mis_flag", 32'(got_mis), 32'd0);
`else
        send(32'h8000_0001, SIZE_W, 1'b0, 1'b0, 32'h0);
        wait_rsp("mis");
        chk("mis_ar_cnt", 32'(ar_cnt - base), 32'd0);
        chk("mis_rdata", got_rdata, 32'h0);
        chk("mis_flag", 32'(got_mis), 32'd1);
`endif

        // Back-to-back with rsp_ready low: FSM parked on X, A and B fill the queue, C stalls
        rd_data_q.push_back(32'h1111_1111); rd_resp_q.push_back(AXI_RESP_OKAY);
        send(32'h8000_0100, SIZE_W, 1'b0, 1'b0, 32'h0);
        guard = 0;
        while (!rsp_valid && guard < 60) begin tick(); guard++; end
        chk("b2b_x_valid", 32'(rsp_valid), 32'd1);
        rd_data_q.push_back(32'hAAAA_0001); rd_resp_q.push_back(AXI_RESP_OKAY);
        rd_data_q.push_back(32'hBBBB_0002); rd_resp_q.push_back(AXI_RESP_OKAY);
        rd_data_q.push_back(32'hCCCC_0003); rd_resp_q.push_back(AXI_RESP_OKAY);
        send(32'h8000_0104, SIZE_W, 1'b0, 1'b0, 32'h0);
        send(32'h8000_0108, SIZE_W, 1'b0, 1'b0, 32'h0);
        chk("b2b_full", 32'(req_ready), 32'd0);
        drive(32'h8000_010C, SIZE_W, 1'b0, 1'b0, 32'h0);
        tick();
        chk("b2b_stall1", 32'(req_ready), 32'd0);
        tick();
        chk("b2b_stall2", 32'(req_ready), 32'd0);
        chk("b2b_x_held", rsp_rdata, 32'h1111_1111);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            bit acc;
            acc = req_valid && req_ready;
            if (rsp_valid) begin resp_log[got] = rsp_rdata; got++; end
            tick();
            if (acc) req_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        chk("b2b_count", 32'(got), 32'd4);
        chk("b2b_r0", resp_log[0], 32'h1111_1111);
        chk("b2b_r1", resp_log[1], 32'hAAAA_0001);
        chk("b2b_r2", resp_log[2], 32'hBBBB_0002);
        chk("b2b_r3", resp_log[3], 32'hCCCC_0003);

        // SLVERR on LW
        rd_data_q.push_back(32'h1234_5678); rd_resp_q.push_back(AXI_RESP_SLVERR);
        send(32'h8000_0010, SIZE_W, 1'b0, 1'b0, 32'h0);
        wait_rsp("err");
        chk("err_flag", 32'(got_err), 32'd1);
        chk("err_rdata", got_rdata, 32'h0);

        // Reset while waiting for R, with two more requests queued behind
        r_hold = 1;
        rd_data_q.push_back(32'h0BAD_0BAD); rd_resp_q.push_back(AXI_RESP_OKAY);
        send(32'h8000_0040, SIZE_W, 1'b0, 1'b0, 32'h0);
        send(32'h8000_0044, SIZE_W, 1'b0, 1'b0, 32'h0);
        send(32'h8000_0048, SIZE_W, 1'b0, 1'b0, 32'h0);
        guard = 0;
        while (!r_m2s.rready && guard < 20) begin tick(); guard++; end
        chk("rstw_in_wait", 32'(r_m2s.rready), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstw_arvalid", 32'(r_m2s.arvalid), 32'd0);
        chk("rstw_rready", 32'(r_m2s.rready), 32'd0);
        chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_awvalid", 32'(w_m2s.awvalid), 32'd0);
        tick(); tick();
        reset = 1'b1;
        r_hold = 0;
        rd_data_q.delete(); rd_resp_q.delete();
        base = ar_cnt;
        repeat (8) tick();
        chk("rstw_no_ar", 32'(ar_cnt - base), 32'd0);
        chk("rstw_rsp_idle", 32'(rsp_valid), 32'd0);
        chk("rstw_req_ready", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
